// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetch and MEM load/store requests onto one fixed-latency memory port.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed DM priority.
module mem_port_arbiter #(
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   output logic        if_err,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [2:0]  dm_type,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic        dm_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [2:0]  mem_type,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      ERR
   } state_t;

   state_t            state;
   logic              grant_dm;
   logic              we_q;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       if_rdata_q;
   logic [31:0]       dm_rdata_q;
   logic [31:0]       mem_addr_q;
   logic [2:0]        mem_type_q;
   logic [31:0]       mem_wdata_q;
`ifdef ARB_RR_EN
   logic              last_grant_dm;
`endif

   logic              done;
   logic              if_cand;
   logic              dm_cand;
   logic              pick_dm;
   logic              any_req;
   logic              sel_misaligned;

   // Unknown dm_type encodings fall into the word rule.
   function automatic logic misaligned(input logic is_fetch, input logic [2:0] typ,
                                       input logic [1:0] a);
      logic res;
      res = 1'b0;
      if (is_fetch) begin
         res = (a != 2'b00);
      end else begin
         case (typ)
            3'b001, 3'b010: res = a[0];
            3'b011, 3'b100: res = 1'b0;
            default:        res = (a != 2'b00);
         endcase
      end
      return res;
   endfunction

   assign done      = (state == RESP) || (state == ERR);
   assign if_ready  = done && !grant_dm;
   assign dm_ready  = done && grant_dm;
   assign if_err    = (state == ERR) && !grant_dm;
   assign dm_err    = (state == ERR) && grant_dm;
   assign mem_en    = (state == ISSUE);
   assign mem_we    = (state == ISSUE) && grant_dm && we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_type  = mem_type_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;

   // A requester still holds req during its own ready cycle, so it must not be re-granted then.
   always_comb begin
      if_cand        = if_req && !if_ready;
      dm_cand        = dm_req && !dm_ready;
      any_req        = if_cand || dm_cand;
`ifdef ARB_RR_EN
      pick_dm        = dm_cand && (!if_cand || !last_grant_dm);
`else
      pick_dm        = dm_cand;
`endif
      sel_misaligned = pick_dm ? misaligned(1'b0, dm_type, dm_addr[1:0])
                               : misaligned(1'b1, 3'b000, if_addr[1:0]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         grant_dm      <= 1'b0;
         we_q          <= 1'b0;
         cnt           <= '0;
         if_rdata_q    <= '0;
         dm_rdata_q    <= '0;
         mem_addr_q    <= '0;
         mem_type_q    <= '0;
         mem_wdata_q   <= '0;
`ifdef ARB_RR_EN
         last_grant_dm <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, RESP, ERR: begin
               if (any_req) begin
                  grant_dm    <= pick_dm;
                  we_q        <= pick_dm && dm_we;
                  mem_addr_q  <= pick_dm ? dm_addr : if_addr;
                  mem_type_q  <= pick_dm ? dm_type : 3'b000;
                  mem_wdata_q <= pick_dm ? dm_wdata : 32'h0;
`ifdef ARB_RR_EN
                  last_grant_dm <= pick_dm;
`endif
                  state       <= sel_misaligned ? ERR : ISSUE;
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE: begin
               cnt   <= CNT_W'(MEM_LAT);
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               // mem_rdata is valid exactly in the last WAIT cycle.
               if (cnt == CNT_W'(1)) begin
                  if (grant_dm) begin
                     dm_rdata_q <= mem_rdata;
                  end else begin
                     if_rdata_q <= mem_rdata;
                  end
                  state <= RESP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=2) with a fixed-latency memory model.
module tb_mem_port_arbiter;

   localparam int MEM_LAT = 2;

   logic        clk = 1'b0;
   logic        rstn;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        if_err;
   logic        dm_req;
   logic        dm_we;
   logic [2:0]  dm_type;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        dm_err;
   logic        mem_en;
   logic        mem_we;
   logic [2:0]  mem_type;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;

   int checks = 0;
   int errors = 0;
   int pulses;

   logic [15:0] en_hist = '0;
   logic [31:0] data_hist [0:15];

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .CNT_W(4)) dut (
      .clk(clk), .rstn(rstn),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ready(if_ready), .if_err(if_err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_err(dm_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memData(input logic [31:0] a);
      return (a == 32'h100) ? 32'h00500093 : (a ^ 32'hC0DE0000);
   endfunction

   // Memory answers only in the cycle MEM_LAT after mem_en; otherwise it drives garbage.
   always @(negedge clk) begin
      for (int i = 15; i > 0; i--) begin
         en_hist[i]   = en_hist[i-1];
         data_hist[i] = data_hist[i-1];
      end
      en_hist[0]   = mem_en;
      data_hist[0] = memData(mem_addr);
      mem_rdata    = en_hist[MEM_LAT] ? data_hist[MEM_LAT] : 32'hBAD0BAD0;
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic dwe, input logic [2:0] dtype,
                                input logic [31:0] daddr, input logic [31:0] dwdata);
      if_req   = ireq;
      if_addr  = iaddr;
      dm_req   = dreq;
      dm_we    = dwe;
      dm_type  = dtype;
      dm_addr  = daddr;
      dm_wdata = dwdata;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      rstn = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_if_ready", {31'b0, if_ready}, 32'h0);
      checkOutput("rst_dm_ready", {31'b0, dm_ready}, 32'h0);
      checkOutput("rst_mem_en", {31'b0, mem_en}, 32'h0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      checkOutput("rst_if_rdata", if_rdata, 32'h0);
      checkOutput("rst_dm_rdata", dm_rdata, 32'h0);
      rstn = 1'b1;
      stepCycle();

      $display("[TB] fetch at 0x100");
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      stepCycle();
      checkOutput("f_mem_en_c1", {31'b0, mem_en}, 32'h1);
      checkOutput("f_mem_addr_c1", mem_addr, 32'h100);
      checkOutput("f_mem_we_c1", {31'b0, mem_we}, 32'h0);
      checkOutput("f_mem_type_c1", {29'b0, mem_type}, 32'h0);
      stepCycle();
      checkOutput("f_mem_en_c2", {31'b0, mem_en}, 32'h0);
      stepCycle();
      checkOutput("f_if_ready_c3", {31'b0, if_ready}, 32'h0);
      stepCycle();
      checkOutput("f_if_ready_c4", {31'b0, if_ready}, 32'h1);
      checkOutput("f_if_rdata_c4", if_rdata, 32'h00500093);
      checkOutput("f_if_err_c4", {31'b0, if_err}, 32'h0);
      if_req = 1'b0;
      stepCycle();
      checkOutput("f_if_ready_c5", {31'b0, if_ready}, 32'h0);
      checkOutput("f_mem_en_c5", {31'b0, mem_en}, 32'h0);

      $display("[TB] word store at 0x2004");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 3'b000, 32'h2004, 32'hDEADBEEF);
      pulses = 0;
      stepCycle();
      pulses += int'(if_ready);
      checkOutput("s_mem_en_c1", {31'b0, mem_en}, 32'h1);
      checkOutput("s_mem_we_c1", {31'b0, mem_we}, 32'h1);
      checkOutput("s_mem_wdata_c1", mem_wdata, 32'hDEADBEEF);
      checkOutput("s_mem_addr_c1", mem_addr, 32'h2004);
      stepCycle();
      pulses += int'(if_ready);
      checkOutput("s_mem_we_c2", {31'b0, mem_we}, 32'h0);
      stepCycle();
      pulses += int'(if_ready);
      checkOutput("s_dm_ready_c3", {31'b0, dm_ready}, 32'h0);
      stepCycle();
      pulses += int'(if_ready);
      checkOutput("s_dm_ready_c4", {31'b0, dm_ready}, 32'h1);
      checkOutput("s_dm_err_c4", {31'b0, dm_err}, 32'h0);
      checkOutput("s_dm_rdata_c4", dm_rdata, 32'hC0DE2004);
      checkOutput("s_if_pulses", pulses, 32'h0);
      checkOutput("s_if_rdata_hold", if_rdata, 32'h00500093);
      dm_req = 1'b0;
      stepCycle();

      $display("[TB] simultaneous IF and DM requests");
      applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 3'b000, 32'h3000, 32'h0);
`ifdef ARB_RR_EN
      stepCycle();
      checkOutput("b_first_addr", mem_addr, 32'h104);
      repeat (3) stepCycle();
      checkOutput("b_first_if_ready", {31'b0, if_ready}, 32'h1);
      checkOutput("b_first_dm_ready", {31'b0, dm_ready}, 32'h0);
      checkOutput("b_first_if_rdata", if_rdata, 32'hC0DE0104);
      if_req = 1'b0;
      stepCycle();
      checkOutput("b_second_mem_en", {31'b0, mem_en}, 32'h1);
      checkOutput("b_second_addr", mem_addr, 32'h3000);
      repeat (3) stepCycle();
      checkOutput("b_second_dm_ready", {31'b0, dm_ready}, 32'h1);
      checkOutput("b_second_dm_rdata", dm_rdata, 32'hC0DE3000);
      dm_req = 1'b0;
`else
      stepCycle();
      checkOutput("b_first_addr", mem_addr, 32'h3000);
      repeat (3) stepCycle();
      checkOutput("b_first_dm_ready", {31'b0, dm_ready}, 32'h1);
      checkOutput("b_first_if_ready", {31'b0, if_ready}, 32'h0);
      checkOutput("b_first_dm_rdata", dm_rdata, 32'hC0DE3000);
      dm_req = 1'b0;
      stepCycle();
      checkOutput("b_second_mem_en", {31'b0, mem_en}, 32'h1);
      checkOutput("b_second_addr", mem_addr, 32'h104);
      repeat (3) stepCycle();
      checkOutput("b_second_if_ready", {31'b0, if_ready}, 32'h1);
      checkOutput("b_second_if_rdata", if_rdata, 32'hC0DE0104);
      if_req = 1'b0;
`endif
      stepCycle();

      $display("[TB] misaligned half load at 0x2001");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 3'b001, 32'h2001, 32'h0);
      stepCycle();
      checkOutput("mh_dm_ready_c1", {31'b0, dm_ready}, 32'h1);
      checkOutput("mh_dm_err_c1", {31'b0, dm_err}, 32'h1);
      checkOutput("mh_mem_en_c1", {31'b0, mem_en}, 32'h0);
      checkOutput("mh_dm_rdata_c1", dm_rdata, 32'hC0DE3000);
      dm_req = 1'b0;
      stepCycle();
      checkOutput("mh_dm_ready_c2", {31'b0, dm_ready}, 32'h0);
      checkOutput("mh_mem_en_c2", {31'b0, mem_en}, 32'h0);

      $display("[TB] misaligned fetch at 0x102");
      applyStimulus(1'b1, 32'h102, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      stepCycle();
      checkOutput("mf_if_ready_c1", {31'b0, if_ready}, 32'h1);
      checkOutput("mf_if_err_c1", {31'b0, if_err}, 32'h1);
      checkOutput("mf_mem_en_c1", {31'b0, mem_en}, 32'h0);
      checkOutput("mf_if_rdata_c1", if_rdata, 32'hC0DE0104);
      if_req = 1'b0;
      stepCycle();

      $display("[TB] signed byte load at 0x2003");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 3'b011, 32'h2003, 32'h0);
      stepCycle();
      checkOutput("by_mem_en_c1", {31'b0, mem_en}, 32'h1);
      checkOutput("by_mem_type_c1", {29'b0, mem_type}, 32'h3);
      checkOutput("by_dm_ready_c1", {31'b0, dm_ready}, 32'h0);
      repeat (3) stepCycle();
      checkOutput("by_dm_ready_c4", {31'b0, dm_ready}, 32'h1);
      checkOutput("by_dm_err_c4", {31'b0, dm_err}, 32'h0);
      checkOutput("by_dm_rdata_c4", dm_rdata, 32'hC0DE2003);
      dm_req = 1'b0;
      stepCycle();

      $display("[TB] reset during WAIT");
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      stepCycle();
      checkOutput("rw_mem_en_c1", {31'b0, mem_en}, 32'h1);
      stepCycle();
      rstn = 1'b0;
      #1;
      checkOutput("rw_if_ready", {31'b0, if_ready}, 32'h0);
      checkOutput("rw_mem_addr", mem_addr, 32'h0);
      checkOutput("rw_if_rdata", if_rdata, 32'h0);
      checkOutput("rw_dm_rdata", dm_rdata, 32'h0);
      if_req = 1'b0;
      stepCycle();
      rstn = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         stepCycle();
         pulses += int'(if_ready) + int'(dm_ready) + int'(mem_en);
      end
      checkOutput("rw_no_activity", pulses, 32'h0);
      checkOutput("rw_if_rdata_after", if_rdata, 32'h0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      stepCycle();
      checkOutput("rw_new_mem_en", {31'b0, mem_en}, 32'h1);
      repeat (3) stepCycle();
      checkOutput("rw_new_if_ready", {31'b0, if_ready}, 32'h1);
      checkOutput("rw_new_if_rdata", if_rdata, 32'h00500093);
      if_req = 1'b0;
      stepCycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
